// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: bit-period calculation,
// receiver state encoding and the ASCII control codes used as line markers.
package uart_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Number of system clocks per serial bit (truncating division).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read. Occupancy is tracked with a
// registered count; full and empty are derived from that count so that
// equal pointers are never ambiguous.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_acc,
    output logic                     pop_acc
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_nxt;

    // A pop frees the head slot on the same edge, so a full FIFO still
    // accepts a push when a pop happens alongside it.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    // Empty FIFO presents zero rather than stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt = count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

    // Storage write; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_line_fifo.sv
// UART receiver front end: synchronizes RXD, deserializes 8N1 frames,
// queues bytes in a show-ahead FIFO and counts queued end-of-line bytes so
// firmware can tell when a complete line is waiting.
module uart_rx_line_fifo import uart_pkg::*; #(
    parameter int          CLK_FREQ = 25000000,
    parameter int          BAUD     = 115200,
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  EOL      = ASCII_LF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    RXD,
    input  logic                    rd_en,
    input  logic                    clr_err,
    output logic [7:0]              rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    line_pending,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam int CW           = $clog2(DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(HALF_BIT);

    logic           rxd_meta;
    logic           rxs;

    rx_state_t      state, state_nxt;
    logic [BW-1:0]  baud_cnt, baud_nxt;
    logic [2:0]     bit_cnt, bit_nxt;
    logic [7:0]     shift_reg;
    logic           sample;
    logic           push_nxt;
    logic           push_p1;
    logic           ferr_set;

    logic           fifo_push_acc;
    logic           fifo_pop_acc;
    logic           eol_in;
    logic           eol_out;
    logic [CW-1:0]  eol_cnt, eol_nxt;
    logic           overrun_set;

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxs      <= rxd_meta;
        end
    end

    // Receiver control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            push_p1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            push_p1  <= push_nxt;
        end
    end

    // Frame sequencing: mid-bit check of the start bit, then one sample per
    // bit period for the data and stop bits.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        sample    = 1'b0;
        push_nxt  = 1'b0;
        ferr_set  = 1'b0;
        unique case (state)
            IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (baud_cnt == BAUD_HALF) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    // Line back high at mid-start means it was a glitch.
                    state_nxt = rxs ? IDLE : DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    sample   = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                    else                 bit_nxt   = bit_cnt + 1'b1;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                    if (rxs) push_nxt = 1'b1;
                    else     ferr_set = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data shift register, LSB first; holds the byte until the push cycle.
    always_ff @(posedge clk) begin
        if (sample) shift_reg <= {rxs, shift_reg[7:1]};
    end

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_p1),
        .push_data (shift_reg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .push_acc  (fifo_push_acc),
        .pop_acc   (fifo_pop_acc)
    );

    // Only bytes actually stored or actually removed move the line count.
    assign eol_in      = fifo_push_acc & (shift_reg == EOL);
    assign eol_out     = fifo_pop_acc & (rd_data == EOL);
    assign overrun_set = push_p1 & ~fifo_push_acc;

    // Next EOL count from the stored/removed EOL pair.
    always_comb begin
        eol_nxt = eol_cnt;
        case ({eol_in, eol_out})
            2'b10:   eol_nxt = eol_cnt + 1'b1;
            2'b01:   eol_nxt = eol_cnt - 1'b1;
            default: eol_nxt = eol_cnt;
        endcase
    end

    // EOL count and its registered summary flag, aligned with FIFO status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eol_cnt      <= '0;
            line_pending <= 1'b0;
        end else begin
            eol_cnt      <= eol_nxt;
            line_pending <= (eol_nxt != '0);
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (overrun_set)  overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

endmodule
